fetch_queue: RTL and testbench

Instruction-fetch stage directly downstream of the program counter. It owns the fetch PC, issues word reads to a synchronous instruction memory, and buffers returned {pc, instruction} pairs in a small FIFO for the decode stage. A valid/ready handshake decouples decode stalls from fetch. A redirect input (branch/jump/exception) flushes the buffer and restarts fetch at a new address.

---
 rtl/fetch_queue.sv | 106 ++++++++++
 tb/tb_fetch_queue.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: owns the fetch PC, issues word reads to a synchronous
// instruction memory and buffers returned {pc, instruction} pairs for decode.
//
// Handshake (inst_valid/inst_ready): inst_valid only depends on stored state,
// never on inst_ready; inst_pc/inst_data are stable while inst_valid is high;
// the head entry is consumed on a rising clk edge where inst_valid and
// inst_ready are both 1 (and no reset or redirect takes priority).
module fetch_queue #(
  parameter int            N        = 32,
  parameter int            DEPTH    = 4,
  parameter logic [N-1:0]  RESET_PC = 32'h00400000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     redirect_valid,
  input  logic [N-1:0]             redirect_pc,
  output logic                     imem_req,
  output logic [N-1:0]             imem_addr,
  input  logic [N-1:0]             imem_rdata,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [N-1:0]             inst_pc,
  output logic [N-1:0]             inst_data,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [N-1:0]  fetch_pc;
  logic [N-1:0]  inflight_pc;
  logic          inflight;
  logic          kill;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [N-1:0]  pc_mem   [DEPTH];
  logic [N-1:0]  data_mem [DEPTH];

  logic [CW-1:0] fill;
  logic          issue;
  logic          push;
  logic          pop;
  logic          unused_low_bits;

  // The two low redirect address bits are dropped: fetch is word-aligned.
  assign unused_low_bits = ^redirect_pc[1:0];

  // Issue decision counts the in-flight slot and ignores a same-cycle pop,
  // so the buffer can never overflow when the response lands.
  assign fill  = count + {{(CW-1){1'b0}}, inflight};
  assign issue = !reset && !redirect_valid && (fill < CW'(DEPTH));
  assign push  = inflight && !kill;
  assign pop   = inst_valid && inst_ready;

  assign imem_req   = issue;
  assign imem_addr  = reset ? RESET_PC : fetch_pc;
  assign inst_valid = !reset && (count != '0);
  assign inst_pc    = inst_valid ? pc_mem[rd_ptr]   : '0;
  assign inst_data  = inst_valid ? data_mem[rd_ptr] : '0;
  assign occupancy  = reset ? '0 : fill;

  // Control state: fetch PC, pointers, count, in-flight tracking and kill.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      kill        <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[N-1:2], 2'b00};
      inflight <= 1'b0;
      // A response still owed for the old stream must not be stored.
      kill     <= inflight;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      kill     <= 1'b0;
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + N'(4);
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage: capture the returned word together with its PC.
  always_ff @(posedge clk) begin
    if (!reset && !redirect_valid && push) begin
      pc_mem[wr_ptr]   <= inflight_pc;
      data_mem[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios for fetch_queue with a one-cycle
// synchronous instruction memory model.
module tb_fetch_queue;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic [2:0]  occupancy;

  int n_cmp = 0;
  int n_err = 0;
  logic data_mode = 1'b0;

  fetch_queue #(.N(32), .DEPTH(4), .RESET_PC(32'h00400000)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_pc        (inst_pc),
    .inst_data      (inst_data),
    .occupancy      (occupancy)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory contents: constant NOP or an address-dependent pattern.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return data_mode ? (a ^ 32'h13579BDF) : 32'h00000013;
  endfunction

  // Synchronous instruction memory: data valid the cycle after the request.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? mem_fn(imem_addr) : 32'hDEADBEEF;
  end

  // Driver: hold reset for two edges, return at a negedge with reset still high.
  task automatic do_reset();
    @(negedge clk);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b exp 0", imem_req); end
    n_cmp++; if (imem_addr !== 32'h00400000) begin n_err++; $display("FAIL reset_addr got %h exp 00400000", imem_addr); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", inst_valid); end
    n_cmp++; if (inst_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h exp 0", inst_pc); end
    n_cmp++; if (inst_data !== 32'h0) begin n_err++; $display("FAIL reset_data got %h exp 0", inst_data); end
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
  endtask

  // Release reset with decode always ready: one word per cycle after 2-cycle latency.
  task automatic test_stream();
    logic [31:0] e;
    logic [2:0]  eo;
    do_reset();
    data_mode  = 1'b0;
    reset      = 1'b0;
    inst_ready = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      e = 32'h00400000 + 32'(4 * k);
      n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL stream_req k=%0d got %b exp 1", k, imem_req); end
      n_cmp++; if (imem_addr !== e) begin n_err++; $display("FAIL stream_addr k=%0d got %h exp %h", k, imem_addr, e); end
      eo = (k == 0) ? 3'd0 : ((k == 1) ? 3'd1 : 3'd2);
      n_cmp++; if (occupancy !== eo) begin n_err++; $display("FAIL stream_occ k=%0d got %0d exp %0d", k, occupancy, eo); end
      if (k < 2) begin
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL stream_early_valid k=%0d got %b exp 0", k, inst_valid); end
      end else begin
        e = 32'h00400000 + 32'(4 * (k - 2));
        n_cmp++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid k=%0d got %b exp 1", k, inst_valid); end
        n_cmp++; if (inst_pc !== e) begin n_err++; $display("FAIL stream_pc k=%0d got %h exp %h", k, inst_pc, e); end
        n_cmp++; if (inst_data !== 32'h00000013) begin n_err++; $display("FAIL stream_data k=%0d got %h exp 00000013", k, inst_data); end
      end
    end
  endtask

  // Decode stalled: exactly DEPTH issues, then fetch stops until a pop.
  task automatic test_stall();
    logic [31:0] e;
    do_reset();
    data_mode  = 1'b1;
    reset      = 1'b0;
    inst_ready = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      e = 32'h00400000 + 32'(4 * k);
      n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL stall_req k=%0d got %b exp 1", k, imem_req); end
      n_cmp++; if (imem_addr !== e) begin n_err++; $display("FAIL stall_addr k=%0d got %h exp %h", k, imem_addr, e); end
    end
    @(negedge clk); #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL stall_req_full1 got %b exp 0", imem_req); end
    n_cmp++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL stall_occ1 got %0d exp 4", occupancy); end
    @(negedge clk); #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL stall_req_full2 got %b exp 0", imem_req); end
    n_cmp++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL stall_occ2 got %0d exp 4", occupancy); end
    n_cmp++; if (inst_pc !== 32'h00400000) begin n_err++; $display("FAIL stall_head got %h exp 00400000", inst_pc); end
    inst_ready = 1'b1;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL stall_req_conservative got %b exp 0", imem_req); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      e = 32'h00400004 + 32'(4 * k);
      n_cmp++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL drain_valid k=%0d got %b exp 1", k, inst_valid); end
      n_cmp++; if (inst_pc !== e) begin n_err++; $display("FAIL drain_pc k=%0d got %h exp %h", k, inst_pc, e); end
      n_cmp++; if (inst_data !== mem_fn(e)) begin n_err++; $display("FAIL drain_data k=%0d got %h exp %h", k, inst_data, mem_fn(e)); end
      if (k == 0) begin
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL resume_req got %b exp 1", imem_req); end
        n_cmp++; if (imem_addr !== 32'h00400010) begin n_err++; $display("FAIL resume_addr got %h exp 00400010", imem_addr); end
      end
    end
  endtask

  // Redirect with a request in flight and a pop on the same edge.
  task automatic test_redirect();
    do_reset();
    data_mode  = 1'b1;
    reset      = 1'b0;
    inst_ready = 1'b1;
    #1;
    @(negedge clk); @(negedge clk); @(negedge clk); #1;
    n_cmp++; if (inst_pc !== 32'h00400004) begin n_err++; $display("FAIL redir_pre_pc got %h exp 00400004", inst_pc); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h00400103;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL redir_req got %b exp 0", imem_req); end
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL redir_valid1 got %b exp 0", inst_valid); end
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL redir_req1 got %b exp 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h00400100) begin n_err++; $display("FAIL redir_addr got %h exp 00400100", imem_addr); end
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL redir_occ got %0d exp 0", occupancy); end
    @(negedge clk); #1;
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL redir_valid2 got %b exp 0", inst_valid); end
    n_cmp++; if (occupancy !== 3'd1) begin n_err++; $display("FAIL redir_occ2 got %0d exp 1", occupancy); end
    @(negedge clk); #1;
    n_cmp++; if (inst_pc !== 32'h00400100) begin n_err++; $display("FAIL redir_first_pc got %h exp 00400100", inst_pc); end
    n_cmp++; if (inst_data !== mem_fn(32'h00400100)) begin n_err++; $display("FAIL redir_first_data got %h exp %h", inst_data, mem_fn(32'h00400100)); end
    @(negedge clk); #1;
    n_cmp++; if (inst_pc !== 32'h00400104) begin n_err++; $display("FAIL redir_second_pc got %h exp 00400104", inst_pc); end
  endtask

  // Redirect on the first pop edge, followed by a second redirect: last one wins.
  task automatic test_back_to_back();
    do_reset();
    data_mode  = 1'b1;
    reset      = 1'b0;
    inst_ready = 1'b1;
    #1;
    @(negedge clk); @(negedge clk); #1;
    n_cmp++; if (inst_pc !== 32'h00400000) begin n_err++; $display("FAIL b2b_pre_pc got %h exp 00400000", inst_pc); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h00500000;
    @(negedge clk);
    redirect_pc    = 32'h00400206;
    #1;
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL b2b_valid0 got %b exp 0", inst_valid); end
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL b2b_req0 got %b exp 0", imem_req); end
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    n_cmp++; if (imem_addr !== 32'h00400204) begin n_err++; $display("FAIL b2b_addr got %h exp 00400204", imem_addr); end
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL b2b_occ got %0d exp 0", occupancy); end
    @(negedge clk); #1;
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL b2b_valid1 got %b exp 0", inst_valid); end
    @(negedge clk); #1;
    n_cmp++; if (inst_pc !== 32'h00400204) begin n_err++; $display("FAIL b2b_first_pc got %h exp 00400204", inst_pc); end
    @(negedge clk); #1;
    n_cmp++; if (inst_pc !== 32'h00400208) begin n_err++; $display("FAIL b2b_second_pc got %h exp 00400208", inst_pc); end
  endtask

  // Reset asserted while three entries are stored and one is in flight.
  task automatic test_reset_mid();
    do_reset();
    data_mode  = 1'b1;
    reset      = 1'b0;
    inst_ready = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) @(negedge clk);
    #1;
    n_cmp++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL rmid_occ_pre got %0d exp 4", occupancy); end
    reset = 1'b1;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rmid_req got %b exp 0", imem_req); end
    n_cmp++; if (imem_addr !== 32'h00400000) begin n_err++; $display("FAIL rmid_addr got %h exp 00400000", imem_addr); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid got %b exp 0", inst_valid); end
    n_cmp++; if (inst_pc !== 32'h0) begin n_err++; $display("FAIL rmid_pc got %h exp 0", inst_pc); end
    n_cmp++; if (inst_data !== 32'h0) begin n_err++; $display("FAIL rmid_data got %h exp 0", inst_data); end
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL rmid_occ got %0d exp 0", occupancy); end
    @(negedge clk);
    reset      = 1'b0;
    inst_ready = 1'b1;
    #1;
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL rmid_req_after got %b exp 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h00400000) begin n_err++; $display("FAIL rmid_addr_after got %h exp 00400000", imem_addr); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid_after got %b exp 0", inst_valid); end
    @(negedge clk); #1;
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid_after2 got %b exp 0", inst_valid); end
    @(negedge clk); #1;
    n_cmp++; if (inst_pc !== 32'h00400000) begin n_err++; $display("FAIL rmid_first_pc got %h exp 00400000", inst_pc); end
  endtask

  // Fetch PC wraps from the top of the address space to zero.
  task automatic test_wrap();
    logic [31:0] e;
    do_reset();
    data_mode  = 1'b1;
    reset      = 1'b0;
    inst_ready = 1'b1;
    #1;
    @(negedge clk); @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFFFFF8;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      if (k < 3) begin
        e = 32'hFFFFFFF8 + 32'(4 * k);
        n_cmp++; if (imem_addr !== e) begin n_err++; $display("FAIL wrap_addr k=%0d got %h exp %h", k, imem_addr, e); end
      end
      if (k >= 2) begin
        e = 32'hFFFFFFF8 + 32'(4 * (k - 2));
        n_cmp++; if (inst_pc !== e) begin n_err++; $display("FAIL wrap_pc k=%0d got %h exp %h", k, inst_pc, e); end
        n_cmp++; if (inst_data !== mem_fn(e)) begin n_err++; $display("FAIL wrap_data k=%0d got %h exp %h", k, inst_data, mem_fn(e)); end
      end
    end
  endtask

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
